// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared Pong VGA timing, geometry and FSM state definitions
package pong_pkg;

    typedef logic [10:0] coord_t;

    localparam coord_t H_ACTIVE  = 11'd640;
    localparam coord_t V_ACTIVE  = 11'd480;
    localparam coord_t H_TOTAL   = 11'd800;
    localparam coord_t V_TOTAL   = 11'd525;

    localparam coord_t BALL_SIZE = 11'd16;
    localparam coord_t BALL_HALF = BALL_SIZE >> 1;
    localparam coord_t BORDER    = 11'd8;
    localparam coord_t PADDLE_X  = 11'd32;
    localparam coord_t PADDLE_W  = 11'd8;
    localparam coord_t PADDLE_H  = 11'd64;

    // Bit positions of the per-side flags inside the packed flag vector.
    localparam int SIDE_X1 = 3;
    localparam int SIDE_X2 = 2;
    localparam int SIDE_Y1 = 1;
    localparam int SIDE_Y2 = 0;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        UPDATE
    } state_t;

endpackage

// File: rtl/obstacle_map.sv
// rtl/obstacle_map.sv - combinational playfield border / paddle occupancy lookup
module obstacle_map
    import pong_pkg::*;
(
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic [8:0]  paddle_y,
    output logic        obstacle
);

    coord_t paddle_top;
    logic   on_border;
    logic   on_paddle;

    assign paddle_top = {2'b00, paddle_y};

    assign on_border = (x < BORDER) || (x >= H_ACTIVE - BORDER) ||
                       (y < BORDER) || (y >= V_ACTIVE - BORDER);

    assign on_paddle = (x >= PADDLE_X) && (x < PADDLE_X + PADDLE_W) &&
                       (y >= paddle_top) && (y < paddle_top + PADDLE_H);

    assign obstacle = on_border || on_paddle;

endmodule

// File: rtl/collision_detector.sv
// rtl/collision_detector.sv - per-frame sticky collision flags around the ball
// with a FRAME_DIV-divided one-cycle update strobe for the ball stage.
module collision_detector
    import pong_pkg::*;
#(
    parameter int FRAME_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] CounterX,
    input  logic [9:0] CounterY,
    input  logic [9:0] ballX,
    input  logic [8:0] ballY,
    input  logic [8:0] paddleY,
    input  logic       pause,
    output logic       CollisionX1,
    output logic       CollisionX2,
    output logic       CollisionY1,
    output logic       CollisionY2,
    output logic       ResetCollision
);

    localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    coord_t scan_x;
    coord_t scan_y;
    coord_t ball_l;
    coord_t ball_t;
    coord_t probe_x [4];
    coord_t probe_y [4];
    logic   on_obstacle;
    logic   origin;
    logic   frame_end;
    logic [3:0] hit;

    state_t        state_q,     state_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic          rc_q,        rc_d;
    logic [3:0]    flags_q,     flags_d;

    assign scan_x    = {1'b0, CounterX};
    assign scan_y    = {1'b0, CounterY};
    assign ball_l    = {1'b0, ballX};
    assign ball_t    = {2'b00, ballY};
    assign origin    = (CounterX == 10'd0) && (CounterY == 10'd0);
    assign frame_end = (scan_x == H_TOTAL - 11'd1) && (scan_y == V_TOTAL - 11'd1);

    // A probe only matches when the scan sits on it, so one lookup at the
    // scan position serves all four probes.
    obstacle_map u_obstacle_map (
        .x        (scan_x),
        .y        (scan_y),
        .paddle_y (paddleY),
        .obstacle (on_obstacle)
    );

    always_comb begin
        probe_x[SIDE_X1] = ball_l - 11'd1;
        probe_y[SIDE_X1] = ball_t + BALL_HALF;
        probe_x[SIDE_X2] = ball_l + BALL_SIZE;
        probe_y[SIDE_X2] = ball_t + BALL_HALF;
        probe_x[SIDE_Y1] = ball_l + BALL_HALF;
        probe_y[SIDE_Y1] = ball_t - 11'd1;
        probe_x[SIDE_Y2] = ball_l + BALL_HALF;
        probe_y[SIDE_Y2] = ball_t + BALL_SIZE;
    end

    // Probes off the visible area (incl. wrapped negatives) are never scanned,
    // so they are reported as a hit once per frame at the frame-end pixel.
    always_comb begin
        hit = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if ((probe_x[i] < H_ACTIVE) && (probe_y[i] < V_ACTIVE)) begin
                hit[i] = (scan_x == probe_x[i]) && (scan_y == probe_y[i]) && on_obstacle;
            end else begin
                hit[i] = frame_end;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        rc_d        = 1'b0;
        flags_d     = flags_q;
        case (state_q)
            IDLE: begin
                if (origin) begin
                    state_d = SCAN;
                    flags_d = flags_q | hit;
                end
            end
            SCAN: begin
                flags_d = flags_q | hit;
                if (frame_end && !pause) begin
                    if (frame_cnt_q == CNT_LAST) begin
                        frame_cnt_d = '0;
                        state_d     = UPDATE;
                        rc_d        = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + CNT_ONE;
                    end
                end
            end
            UPDATE: begin
                flags_d = hit;
                state_d = SCAN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            rc_q        <= 1'b0;
            flags_q     <= 4'b0000;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            rc_q        <= rc_d;
            flags_q     <= flags_d;
        end
    end

    assign CollisionX1    = flags_q[SIDE_X1];
    assign CollisionX2    = flags_q[SIDE_X2];
    assign CollisionY1    = flags_q[SIDE_Y1];
    assign CollisionY2    = flags_q[SIDE_Y2];
    assign ResetCollision = rc_q;

endmodule

// File: tb/tb_collision_detector.sv
// tb/tb_collision_detector.sv - directed and random sparse-scan checks of
// collision_detector (FRAME_DIV 1 and 4) against a pixel-level reference model.
module tb_collision_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] cx;
    logic [9:0] cy;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [8:0] paddle_y;
    logic       pause;

    logic c1_x1, c1_x2, c1_y1, c1_y2, c1_rc;
    logic c4_x1, c4_x2, c4_y1, c4_y2, c4_rc;
    logic [4:0] obs1;
    logic [4:0] obs4;

    int passed = 0;
    int total  = 0;

    int         fd [2] = '{1, 4};
    bit         started [2];
    int         frames [2];
    logic       rc [2];
    logic [3:0] flg [2];

    always #5 clk = ~clk;

    collision_detector #(.FRAME_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .CounterX(cx), .CounterY(cy),
        .ballX(ball_x), .ballY(ball_y), .paddleY(paddle_y), .pause(pause),
        .CollisionX1(c1_x1), .CollisionX2(c1_x2), .CollisionY1(c1_y1),
        .CollisionY2(c1_y2), .ResetCollision(c1_rc)
    );

    collision_detector #(.FRAME_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .CounterX(cx), .CounterY(cy),
        .ballX(ball_x), .ballY(ball_y), .paddleY(paddle_y), .pause(pause),
        .CollisionX1(c4_x1), .CollisionX2(c4_x2), .CollisionY1(c4_y1),
        .CollisionY2(c4_y2), .ResetCollision(c4_rc)
    );

    assign obs1 = {c1_x1, c1_x2, c1_y1, c1_y2, c1_rc};
    assign obs4 = {c4_x1, c4_x2, c4_y1, c4_y2, c4_rc};

    function automatic bit is_obstacle(input int x, input int y, input int pt);
        return (x < 8) || (x >= 632) || (y < 8) || (y >= 472) ||
               ((x >= 32) && (x < 40) && (y >= pt) && (y < pt + 64));
    endfunction

    // Probe i: 0=left, 1=right, 2=top, 3=bottom, in signed pixel units.
    task automatic get_probe(input int i, output int x, output int y);
        int bx = int'(ball_x);
        int by = int'(ball_y);
        case (i)
            0:       begin x = bx - 1;  y = by + 8;  end
            1:       begin x = bx + 16; y = by + 8;  end
            2:       begin x = bx + 8;  y = by - 1;  end
            default: begin x = bx + 8;  y = by + 16; end
        endcase
    endtask

    function automatic bit in_area(input int x, input int y);
        return (x >= 0) && (x < 640) && (y >= 0) && (y < 480);
    endfunction

    task automatic model_edge();
        logic [3:0] h;
        int  px, py;
        bit  origin = (cx == 0) && (cy == 0);
        bit  fend   = (cx == 799) && (cy == 524);
        for (int i = 0; i < 4; i++) begin
            get_probe(i, px, py);
            if (in_area(px, py))
                h[3-i] = (int'(cx) == px) && (int'(cy) == py) && is_obstacle(px, py, int'(paddle_y));
            else
                h[3-i] = fend;
        end
        for (int k = 0; k < 2; k++) begin
            if (!started[k]) begin
                if (origin) begin
                    started[k] = 1'b1;
                    flg[k] = flg[k] | h;
                end
            end else if (rc[k]) begin
                flg[k] = h;
                rc[k]  = 1'b0;
            end else begin
                flg[k] = flg[k] | h;
                if (fend && !pause) begin
                    frames[k]++;
                    if (frames[k] == fd[k]) begin
                        frames[k] = 0;
                        rc[k] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [4:0] o, input logic [4:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, o, e);
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk({tag, "/div1"}, obs1, {flg[0], rc[0]});
        chk({tag, "/div4"}, obs4, {flg[1], rc[1]});
    endtask

    task automatic pix(input string tag, input int x, input int y);
        cx = 10'(x);
        cy = 10'(y);
        step(tag);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            started[k] = 1'b0;
            frames[k]  = 0;
            rc[k]      = 1'b0;
            flg[k]     = 4'b0000;
        end
        chk("reset_div1", obs1, 5'b00000);
        chk("reset_div4", obs4, 5'b00000);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Sparse frame: origin, every visible probe pixel, some random pixels, frame end.
    task automatic frame(input string tag, input int nrand, input bit with_origin);
        int px, py, rx, ry;
        if (with_origin) pix(tag, 0, 0);
        for (int i = 0; i < 4; i++) begin
            get_probe(i, px, py);
            if (in_area(px, py)) pix(tag, px, py);
        end
        for (int n = 0; n < nrand; n++) begin
            rx = int'($urandom_range(0, 799));
            ry = int'($urandom_range(0, 524));
            if ((rx == 0 && ry == 0) || (rx == 799 && ry == 524)) rx = 1;
            pix(tag, rx, ry);
        end
        pix(tag, 799, 524);
    endtask

    initial begin
        cx = 10'd300; cy = 10'd100;
        ball_x = 10'd300; ball_y = 9'd200; paddle_y = 9'd200; pause = 1'b0;
        do_reset();

        pix("partial", 500, 300);
        pix("partial", 799, 524);
        chk("no_pulse_partial", obs1, 5'b00000);

        frame("free", 6, 1);
        chk("free_pulse", obs1, 5'b00001);
        frame("free", 6, 1);
        chk("free_pulse2", obs1, 5'b00001);

        ball_x = 10'd616;
        frame("right_wall", 4, 1);
        chk("right_wall_pulse", obs1, 5'b01001);
        ball_x = 10'd300;
        pix("after_pulse", 0, 0);
        chk("after_pulse_clear", obs1, 5'b00000);
        frame("free", 4, 0);

        ball_x = 10'd8; ball_y = 9'd8;
        frame("corner", 4, 1);
        chk("corner_x1_y1", obs1, 5'b10101);
        ball_x = 10'd0; ball_y = 9'd200;
        frame("left_out", 4, 1);
        chk("left_forced", obs1, 5'b10001);

        ball_x = 10'd40; ball_y = 9'd200; paddle_y = 9'd180;
        frame("paddle", 4, 1);
        chk("paddle_hit", obs1, 5'b10001);
        paddle_y = 9'd300;
        frame("paddle_miss", 4, 1);
        chk("paddle_miss", obs1, 5'b00001);

        ball_x = 10'd616; ball_y = 9'd200;
        pix("mid_frame", 0, 0);
        pix("mid_frame", 632, 208);
        cx = 10'd300; cy = 10'd100;
        do_reset();

        frame("div_f1", 3, 1);
        chk("div_f1", obs4, 5'b01000);
        ball_x = 10'd300;
        frame("div_f2", 3, 1);
        chk("div_f2", obs4, 5'b01000);
        frame("div_f3", 3, 1);
        chk("div_f3", obs4, 5'b01000);
        frame("div_f4", 3, 1);
        chk("div_f4_pulse", obs4, 5'b01001);

        ball_x = 10'd616;
        frame("pz_f1", 3, 1);
        chk("pz_f1", obs4, 5'b01000);
        ball_x = 10'd300;
        pause = 1'b1;
        frame("pz_f2", 3, 1);
        chk("pz_f2", obs4, 5'b01000);
        frame("pz_f3", 3, 1);
        chk("pz_f3", obs4, 5'b01000);
        pause = 1'b0;
        frame("pz_f4", 3, 1);
        chk("pz_f4", obs4, 5'b01000);
        frame("pz_f5", 3, 1);
        chk("pz_f5", obs4, 5'b01000);
        frame("pz_f6", 3, 1);
        chk("pz_f6_pulse", obs4, 5'b01001);

        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 1) == 0) begin
                ball_x = 10'($urandom_range(0, 639));
                ball_y = 9'($urandom_range(0, 479));
            end else begin
                ball_x = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 48))
                                                     : 10'($urandom_range(600, 639));
                ball_y = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 16))
                                                     : 9'($urandom_range(450, 479));
            end
            paddle_y = 9'($urandom_range(0, 511));
            pause    = ($urandom_range(0, 3) == 0);
            frame("random", 4, 1);
        end
        pause = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/collision_detector.md
# collision_detector

Per-frame collision sensing for the Pong datapath, sitting directly upstream of the ball position updater. Watches the VGA scan position against four probe pixels just outside the ball's bounding box. Latches a sticky flag per side when a probe pixel lands on an obstacle (playfield border or paddle). Once every FRAME_DIV frames it issues a one-cycle ResetCollision pulse; the ball stage samples the flags and moves on that cycle, and the flags clear.

## Interface
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines
- H_TOTAL, 800, clocks per line including blanking
- V_TOTAL, 525, lines per frame including blanking
- BALL_SIZE, 16, ball square edge in pixels; must be even
- BORDER, 8, border thickness in pixels
- PADDLE_X, 32, paddle left column
- PADDLE_W, 8, paddle width
- PADDLE_H, 64, paddle height
- FRAME_DIV, 1, frames per ball update (≥1)

Ports:
- clk  input  1  pixel clock; the only clock
- rst  input  1  asynchronous, active-low reset
- CounterX  input  10  current scan column, 0..H_TOTAL-1
- CounterY  input  10  current scan line, 0..V_TOTAL-1
- ballX  input  10  ball left column (from ball stage)
- ballY  input  9  ball top line (from ball stage)
- paddleY  input  9  paddle top line
- pause  input  1  freezes frame counting and update pulses
- CollisionX1  output  1  left-side hit
- CollisionX2  output  1  right-side hit
- CollisionY1  output  1  top-side hit
- CollisionY2  output  1  bottom-side hit
- ResetCollision  output  1  one-cycle update strobe

## Operation
- Probes, using 11-bit arithmetic and cx = ballX+BALL_SIZE/2, cy = ballY+BALL_SIZE/2:
  - X1 at (ballX-1, cy)
  - X2 at (ballX+BALL_SIZE, cy)
  - Y1 at (cx, ballY-1)
  - Y2 at (cx, ballY+BALL_SIZE)
- Obstacle pixel: any pixel satisfying one of the following:
  - x<BORDER, x≥H_ACTIVE-BORDER, y<BORDER, or y≥V_ACTIVE-BORDER;
  - x in [PADDLE_X, PADDLE_X+PADDLE_W) and y in [paddleY, paddleY+PADDLE_H).
- Hit: CounterX/CounterY equal to a probe coordinate, inside the active area, and on an obstacle pixel. The matching flag sets.
- Out-of-area probe: a probe coordinate that is negative or outside the active area counts as a hit. The flag is forced set on the frame-end cycle.
- Flags are sticky. They OR-accumulate across all frames until the next update.
- FSM:
  - IDLE: wait for (CounterX,CounterY)=(0,0), then go to SCAN. A partial frame after reset is never used.
  - SCAN: on the frame-end pixel (H_TOTAL-1, V_TOTAL-1) with pause=0:
    - if frame_cnt==FRAME_DIV-1, clear frame_cnt and go to UPDATE;
    - else increment frame_cnt.
    - With pause=1 on the frame-end pixel, frame_cnt holds and flags hold.
  - UPDATE: ResetCollision=1 for exactly this cycle; flags stay stable. Unconditionally return to SCAN.
- Flag clear: on the clock edge ending UPDATE, each flag becomes that cycle's own probe hit. Clear, then OR, so a hit at pixel (0,0) is not lost.
- ballX, ballY and paddleY are sampled live. The ball stage changes them only during UPDATE, so probes are stable within a frame.

## Timing
- Reset values: all Collision* outputs 0, ResetCollision 0, state IDLE, frame_cnt 0.
- Reset is asynchronous and takes effect mid-frame immediately. After release, the first pulse comes at the end of the first full frame following (0,0), no earlier.
- Hit latency: the flag is visible 1 cycle after the probe pixel is scanned.
- ResetCollision is registered and asserted the cycle after the frame-end pixel, i.e. coincident with (0,0) of the next frame.
- Pulse period: FRAME_DIV·H_TOTAL·V_TOTAL cycles with pause=0. Each paused frame extends the period by one frame.
- Both flags of an axis may be set simultaneously; the ball stage treats that as "don't move".

## Structure
- Shared package pong_pkg holds:
  - VGA timing constants (H_ACTIVE, V_ACTIVE, H_TOTAL, V_TOTAL);
  - geometry constants (BALL_SIZE, BORDER, PADDLE_*);
  - FSM state typedef {IDLE, SCAN, UPDATE}.
- One natural sub-module, obstacle_map: combinational (x,y,paddleY) → obstacle. It is reused by the pixel renderer.

## Test plan
- Reset: drive rst low at (300,100) with flags set → all outputs 0 at once. After release, the first ResetCollision comes only after the next (0,0) plus one full frame of 420000 cycles.
- Free ball: ball (300,200), FRAME_DIV=1 → no flags. ResetCollision is high exactly 1 cycle every 420000 cycles, coincident with (0,0).
- Right wall: ballX=616, ballY=200 → X2 probe x=632 hits. During the pulse, CollisionX2=1 and the other flags are 0. The cycle after the pulse, all flags are 0.
- Corners:
  - ballX=8, ballY=8 → X1 and Y1 both set.
  - ballX=0 → X1 forced set at frame end.
- Paddle: ballX=40, ballY=200, paddleY=180 → X1=1, since probe (39,208) is inside the paddle. With paddleY=300 → X1=0.
- Divider and pause: FRAME_DIV=4, ball hits in frame 1 only.
  - CollisionX2 stays 1 until the pulse after frame 4.
  - With pause=1 over frames 2–3, the pulse moves 2 frames later and the flag is still held.
